// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS sweep generator: waveform modes,
// controller states and the sine-table contents function.
package dds_pkg;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 11;
    localparam int DDS_DATA_W = 10;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_TRI    = 2'd3
    } dds_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIXED = 2'd1,
        ST_SWEEP = 2'd2
    } dds_state_e;

    // Bhaskara rational sine, 16q/(5H^2-4q) with q = p(H-p); the pi terms cancel
    // so each table entry is pure integer arithmetic evaluated at elaboration.
    function automatic logic [31:0] dds_sine_code(input int idx, input int addr_w,
                                                  input int data_w);
        longint h;
        longint p;
        longint q;
        longint amp;
        longint num;
        longint den;
        longint mag;
        h   = longint'(1) << (addr_w - 1);
        p   = longint'(idx) % h;
        q   = p * (h - p);
        amp = (longint'(1) << (data_w - 1)) - 1;
        num = 16 * q * amp;
        den = 5 * h * h - 4 * q;
        mag = (2 * num + den) / (2 * den);
        if (longint'(idx) >= h) begin
            return 32'(amp + 1 - mag);
        end
        return 32'(amp + 1 + mag);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Offset-binary sine ROM with a registered read; forms the second output
// pipeline stage and holds its last sample while disabled.
module dds_sine_lut
    import dds_pkg::*;
#(
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_rom [2**ADDR_W];

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_rom
        assign w_rom[g] = DATA_W'(dds_sine_code(g, ADDR_W, DATA_W));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= w_rom[i_addr];
        end
    end

endmodule

// File: rtl/dds_sweep_gen.sv
// Fixed or swept-frequency DDS: config registers, run controller, phase
// accumulator with dwell-based sweep, and a two-stage waveform pipeline.
module dds_sweep_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = DDS_ACC_W,
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_k_start,
    input  logic [ACC_W-1:0]  cfg_k_step,
    input  logic [ACC_W-1:0]  cfg_k_stop,
    input  logic [15:0]       cfg_dwell,
    input  logic [ADDR_W-1:0] cfg_phase,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_sweep,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [DATA_W-1:0] wave_out,
    output logic              wave_valid,
    output logic              sweep_done
);

    dds_state_e        r_state;
    dds_state_e        w_state_next;
    logic [ACC_W-1:0]  r_k_start;
    logic [ACC_W-1:0]  r_k_step;
    logic [ACC_W-1:0]  r_k_stop;
    logic [15:0]       r_dwell;
    logic [ADDR_W-1:0] r_phase;
    dds_mode_e         r_mode;
    logic              r_sweep;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_k_cur;
    logic [15:0]       r_dwell_cnt;
    logic              r_sweep_done;
    logic [ADDR_W-1:0] r_addr;
    dds_mode_e         r_mode1;
    dds_mode_e         r_mode2;
    logic              r_v1;
    logic              r_v2;
    logic [DATA_W-1:0] r_shape;
    logic [DATA_W-1:0] w_shape;
    logic [DATA_W-1:0] w_lut;
    logic              w_run;
    logic              w_cfg_load;
    logic              w_enter;
    logic              w_step;
    logic              w_wrap;
    logic [ACC_W:0]    w_k_sum;
    logic [ADDR_W-1:0] w_code;

    assign w_run      = (r_state != ST_IDLE);
    assign w_cfg_load = cfg_valid && cfg_ready;
    assign w_enter    = (r_state == ST_IDLE) && start;
    assign w_k_sum    = {1'b0, r_k_cur} + {1'b0, r_k_step};
    assign w_step     = (r_state == ST_SWEEP) && (r_dwell_cnt == r_dwell);
    // Zero step never advances, so it must never report a wrap either.
    assign w_wrap     = w_step && (r_k_step != '0) && (w_k_sum > {1'b0, r_k_stop});
    assign w_code     = r_acc[ACC_W-1 -: ADDR_W] + r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_start <= '0;
            r_k_step  <= '0;
            r_k_stop  <= '0;
            r_dwell   <= '0;
            r_phase   <= '0;
            r_mode    <= MODE_SINE;
            r_sweep   <= 1'b0;
        end else if (w_cfg_load) begin
            r_k_start <= cfg_k_start;
            r_k_step  <= cfg_k_step;
            r_k_stop  <= cfg_k_stop;
            r_dwell   <= cfg_dwell;
            r_phase   <= cfg_phase;
            r_mode    <= dds_mode_e'(cfg_mode);
            r_sweep   <= cfg_sweep;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:            if (start) w_state_next = r_sweep ? ST_SWEEP : ST_FIXED;
            ST_FIXED, ST_SWEEP: if (stop)  w_state_next = ST_IDLE;
            default:            w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_k_cur      <= '0;
            r_dwell_cnt  <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sweep_done <= w_wrap;
            if (w_enter) begin
                r_acc       <= '0;
                r_k_cur     <= r_k_start;
                r_dwell_cnt <= '0;
            end else if (w_run) begin
                r_acc <= r_acc + r_k_cur;
                if (w_step) begin
                    r_dwell_cnt <= '0;
                    r_k_cur     <= w_wrap ? r_k_start : w_k_sum[ACC_W-1:0];
                end else if (r_state == ST_SWEEP) begin
                    r_dwell_cnt <= r_dwell_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_mode1 <= MODE_SINE;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= w_run;
            if (w_run) begin
                r_addr  <= w_code;
                r_mode1 <= r_mode;
            end
        end
    end

    always_comb begin
        w_shape = '0;
        case (r_mode1)
            MODE_SAW:    w_shape = r_addr[ADDR_W-1 -: DATA_W];
            MODE_SQUARE: w_shape = r_addr[ADDR_W-1] ? '0 : '1;
            MODE_TRI:    w_shape = r_addr[ADDR_W-1] ? ~r_addr[ADDR_W-2 -: DATA_W]
                                                    :  r_addr[ADDR_W-2 -: DATA_W];
            default:     w_shape = '0;
        endcase
    end

    // Mode travels with its sample so a reconfigure during drain cannot mix shapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shape <= '0;
            r_mode2 <= MODE_SINE;
            r_v2    <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_shape <= w_shape;
                r_mode2 <= r_mode1;
            end
        end
    end

    dds_sine_lut #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sine_lut (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (r_v1),
        .i_addr(r_addr),
        .o_data(w_lut)
    );

    assign cfg_ready  = (r_state == ST_IDLE);
    assign busy       = w_run;
    assign wave_valid = r_v2;
    assign sweep_done = r_sweep_done;
    assign wave_out   = (r_mode2 == MODE_SINE) ? w_lut : r_shape;

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Bench for dds_sweep_gen: vector table, hand-written corner sequences and a
// randomized run compared against an arithmetic model of the sample stream.
module tb_dds_sweep_gen;

    localparam int  NVEC    = 18;
    localparam int  RUN_LEN = 200;
    localparam longint K21  = 64'd2097152;
    localparam longint K22  = 64'd4194304;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_k_start;
    logic [31:0] cfg_k_step;
    logic [31:0] cfg_k_stop;
    logic [15:0] cfg_dwell;
    logic [10:0] cfg_phase;
    logic [1:0]  cfg_mode;
    logic        cfg_sweep;
    logic        start;
    logic        stop;
    logic        busy;
    logic [9:0]  wave_out;
    logic        wave_valid;
    logic        sweep_done;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int     mode;
        longint kword;
        int     phase;
        int     index;
        int     expected;
    } vec_t;

    vec_t   vecs [NVEC];
    longint kTrace [RUN_LEN];
    bit     wTrace [RUN_LEN];
    longint accTrace [RUN_LEN + 1];

    dds_sweep_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_k_start(cfg_k_start),
        .cfg_k_step (cfg_k_step),
        .cfg_k_stop (cfg_k_stop),
        .cfg_dwell  (cfg_dwell),
        .cfg_phase  (cfg_phase),
        .cfg_mode   (cfg_mode),
        .cfg_sweep  (cfg_sweep),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkNear(input string name, input longint actual, input longint expected,
                             input longint tol);
        longint diff;
        diff = actual - expected;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, actual, expected, tol);
        end
    endtask

    task automatic applyStimulus(input int mode, input longint ks, input longint step,
                                 input longint stp, input int dwell, input int phase,
                                 input bit sweep);
        cfg_mode    = 2'(mode);
        cfg_k_start = 32'(ks);
        cfg_k_step  = 32'(step);
        cfg_k_stop  = 32'(stp);
        cfg_dwell   = 16'(dwell);
        cfg_phase   = 11'(phase);
        cfg_sweep   = sweep;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic haltAndDrain;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
    endtask

    // Ideal waveform for a phase code of the 2048-entry cycle.
    function automatic int expShape(input int mode, input int code);
        case (mode)
            1:       return code / 2;
            2:       return (code < 1024) ? 1023 : 0;
            3:       return (code < 1024) ? code : 1023 - (code - 1024);
            default: return int'(512.0 + 511.0 * $sin(2.0 * 3.14159265358979 * code / 2048.0));
        endcase
    endfunction

    // Frequency word per run cycle: each value lasts dwell+1 cycles, then steps or wraps.
    task automatic buildTrace(input longint ks, input longint step, input longint stp,
                              input int dwell, input bit sweep);
        longint k;
        int     i;
        k = ks;
        i = 0;
        while (i < RUN_LEN) begin
            for (int d = 0; d <= dwell && i < RUN_LEN; d++) begin
                kTrace[i] = k;
                wTrace[i] = 1'b0;
                i++;
            end
            if (sweep) begin
                if (step != 0 && k + step > stp) begin
                    wTrace[i-1] = 1'b1;
                    k = ks;
                end else begin
                    k = k + step;
                end
            end
        end
        accTrace[0] = 0;
        for (int n = 0; n < RUN_LEN; n++) begin
            accTrace[n+1] = (accTrace[n] + kTrace[n]) & 64'hFFFF_FFFF;
        end
    endtask

    initial begin
        int     waited;
        int     pulses;
        int     mode;
        int     dwell;
        int     phase;
        int     code;
        bit     sweepBit;
        longint ks;
        longint step;
        longint stp;

        vecs[0]  = '{1, K22, 0,   0,    0};
        vecs[1]  = '{1, K22, 0,   3,    3};
        vecs[2]  = '{1, K22, 0,   1023, 1023};
        vecs[3]  = '{1, K22, 0,   1024, 0};
        vecs[4]  = '{1, K22, 512, 0,    256};
        vecs[5]  = '{1, K22, 512, 767,  1023};
        vecs[6]  = '{1, K22, 512, 768,  0};
        vecs[7]  = '{2, K21, 0,   0,    1023};
        vecs[8]  = '{2, K21, 0,   1023, 1023};
        vecs[9]  = '{2, K21, 0,   1024, 0};
        vecs[10] = '{2, K21, 0,   2047, 0};
        vecs[11] = '{3, K21, 0,   0,    0};
        vecs[12] = '{3, K21, 0,   1023, 1023};
        vecs[13] = '{3, K21, 0,   1024, 1023};
        vecs[14] = '{3, K21, 0,   2047, 0};
        vecs[15] = '{0, K21, 0,   0,    512};
        vecs[16] = '{0, K21, 0,   512,  1023};
        vecs[17] = '{0, K21, 0,   1536, 1};

        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_k_start = '0; cfg_k_step = '0; cfg_k_stop = '0; cfg_dwell = '0;
        cfg_phase = '0; cfg_mode = '0; cfg_sweep = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset cfg_ready", cfg_ready, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset wave_out", wave_out, 0);
        checkOutput("reset wave_valid", wave_valid, 0);
        checkOutput("reset sweep_done", sweep_done, 0);

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].kword, 0, 0, 0, vecs[v].phase, 1'b0);
            pulseStart();
            waited = 0;
            while (!wave_valid && waited < 8) begin
                tick();
                waited++;
            end
            checkOutput($sformatf("vec%0d valid", v), wave_valid, 1);
            repeat (vecs[v].index) tick();
            checkOutput($sformatf("vec%0d sample%0d", v, vecs[v].index), wave_out, vecs[v].expected);
            haltAndDrain();
        end

        // Latency, ignored start/cfg while running, and stop drain timing.
        applyStimulus(1, K22, 0, 0, 0, 0, 1'b0);
        pulseStart();
        checkOutput("run busy", busy, 1);
        checkOutput("run cfg_ready", cfg_ready, 0);
        checkOutput("lat valid+0", wave_valid, 0);
        tick();
        checkOutput("lat valid+1", wave_valid, 0);
        tick();
        checkOutput("lat valid+2", wave_valid, 1);
        checkOutput("lat sample0", wave_out, 0);
        cfg_phase = 11'd700; cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        checkOutput("busy cfg_ready", cfg_ready, 0);
        checkOutput("busy start ignored", busy, 1);
        checkOutput("sample1", wave_out, 1);
        tick();
        checkOutput("sample2", wave_out, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop busy", busy, 0);
        checkOutput("stop cfg_ready", cfg_ready, 1);
        checkOutput("stop valid+0", wave_valid, 1);
        tick();
        checkOutput("stop valid+1", wave_valid, 1);
        checkOutput("stop last sample", wave_out, 4);
        tick();
        checkOutput("stop valid+2", wave_valid, 0);
        checkOutput("hold sample", wave_out, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("idle stop ignored", busy, 0);
        checkOutput("hold sample later", wave_out, 4);
        pulseStart();
        repeat (2) tick();
        checkOutput("restart phase kept", wave_out, 0);
        haltAndDrain();

        // Sweep wrap timing, asynchronous reset mid-sweep, and replay.
        applyStimulus(2, 100, 50, 200, 1, 0, 1'b1);
        pulseStart();
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) tick();
            checkOutput($sformatf("sweep done j%0d", j), sweep_done, (j == 6 || j == 12) ? 1 : 0);
        end
        checkOutput("pre-reset square", wave_out, 1023);
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", busy, 0);
        checkOutput("async rst wave_out", wave_out, 0);
        checkOutput("async rst wave_valid", wave_valid, 0);
        checkOutput("async rst sweep_done", sweep_done, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkOutput("post-rst cfg_ready", cfg_ready, 1);
        pulseStart();
        repeat (2) tick();
        checkOutput("post-rst fixed busy", busy, 1);
        checkOutput("post-rst sine mid", wave_out, 512);
        haltAndDrain();
        applyStimulus(2, 100, 50, 200, 1, 0, 1'b1);
        pulseStart();
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) tick();
            checkOutput($sformatf("replay done j%0d", j), sweep_done, (j == 6 || j == 12) ? 1 : 0);
        end
        haltAndDrain();

        // start above stop wraps at every boundary; zero step never wraps.
        applyStimulus(2, 500, 10, 100, 2, 0, 1'b1);
        pulseStart();
        pulses = 0;
        for (int j = 1; j <= 12; j++) begin tick(); pulses += int'(sweep_done); end
        checkOutput("inverted dwell2 pulses", pulses, 4);
        haltAndDrain();
        applyStimulus(2, 500, 10, 100, 0, 0, 1'b1);
        pulseStart();
        pulses = 0;
        for (int j = 1; j <= 10; j++) begin tick(); pulses += int'(sweep_done); end
        checkOutput("inverted dwell0 pulses", pulses, 10);
        haltAndDrain();
        applyStimulus(2, 100, 0, 200, 0, 0, 1'b1);
        pulseStart();
        pulses = 0;
        for (int j = 1; j <= 20; j++) begin tick(); pulses += int'(sweep_done); end
        checkOutput("zero step pulses", pulses, 0);
        haltAndDrain();

        for (int r = 0; r < 6; r++) begin
            mode     = int'($urandom_range(0, 3));
            sweepBit = 1'($urandom_range(0, 1));
            ks       = longint'($urandom_range(1 << 20, 1 << 24));
            step     = longint'($urandom_range(0, 1 << 22));
            stp      = ($urandom_range(0, 4) == 0) ? ks - 1000 : ks + longint'($urandom_range(0, 1 << 24));
            dwell    = int'($urandom_range(0, 3));
            phase    = int'($urandom_range(0, 2047));
            buildTrace(ks, step, stp, dwell, sweepBit);
            applyStimulus(mode, ks, step, stp, dwell, phase, sweepBit);
            pulseStart();
            for (int j = 0; j < RUN_LEN; j++) begin
                checkOutput($sformatf("rand%0d valid j%0d", r, j), wave_valid, (j >= 2) ? 1 : 0);
                if (j >= 2) begin
                    code = int'(((accTrace[j-2] >> 21) + longint'(phase)) % 2048);
                    if (mode == 0)
                        checkNear($sformatf("rand%0d sine j%0d", r, j), wave_out, expShape(0, code), 2);
                    else
                        checkOutput($sformatf("rand%0d m%0d j%0d", r, mode, j), wave_out, expShape(mode, code));
                end
                checkOutput($sformatf("rand%0d done j%0d", r, j), sweep_done,
                            (j >= 1) ? longint'(wTrace[j-1]) : 0);
                tick();
            end
            haltAndDrain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dds_sweep_gen.md
DDS_SWEEP_GEN -- requirements
Module: dds_sweep_gen

Interface
REQ-001 Parameter ACC_W, default 32, phase accumulator and frequency-word width.
REQ-002 Parameter ADDR_W, default 11, phase-code / waveform-table address width.
REQ-003 Parameter DATA_W, default 10, output sample width; constraint DATA_W <= ADDR_W-1.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration accept, high only in IDLE.
REQ-008 cfg_k_start  in  ACC_W  initial / fixed frequency word.
REQ-009 cfg_k_step  in  ACC_W  sweep increment.
REQ-010 cfg_k_stop  in  ACC_W  sweep upper limit.
REQ-011 cfg_dwell  in  16  extra cycles per sweep step.
REQ-012 cfg_phase  in  ADDR_W  phase offset.
REQ-013 cfg_mode  in  2  waveform: 0 sine, 1 sawtooth, 2 square, 3 triangle.
REQ-014 cfg_sweep  in  1  1 = sweep, 0 = fixed frequency.
REQ-015 start  in  1  run request, honoured in IDLE only.
REQ-016 stop  in  1  halt request, honoured in FIXED/SWEEP only.
REQ-017 busy  out  1  high in FIXED or SWEEP.
REQ-018 wave_out  out  DATA_W  sample.
REQ-019 wave_valid  out  1  wave_out qualifier.
REQ-020 sweep_done  out  1  one-cycle pulse at each sweep wrap.

Function
REQ-021 Config registers load on cycles where cfg_valid && cfg_ready; otherwise hold.
REQ-022 FSM states IDLE, FIXED, SWEEP; IDLE + start -> SWEEP if registered sweep bit set, else FIXED.
REQ-023 FIXED/SWEEP + stop -> IDLE next edge; start in run states, stop in IDLE, are ignored.
REQ-024 On run entry: acc = 0, k_cur = k_start, dwell counter = 0.
REQ-025 Each run cycle acc <= acc + k_cur, modulo 2^ACC_W (wraps silently).
REQ-026 Phase code addr = acc[ACC_W-1 -: ADDR_W] + phase, modulo 2^ADDR_W.
REQ-027 Two-stage output pipeline: addr register, then shaped/LUT sample register; sample for acc value at cycle n appears at n+2.
REQ-028 wave_valid = run flag delayed through the same two stages; low two cycles after IDLE re-entry; wave_out holds last sample when invalid.
REQ-029 Mode 0: sine LUT, 2^ADDR_W entries, offset-binary DATA_W, synchronous read.
REQ-030 Mode 1: wave_out = addr[ADDR_W-1 -: DATA_W].
REQ-031 Mode 2: all ones when addr MSB = 0, zero otherwise.
REQ-032 Mode 3: addr[ADDR_W-2 -: DATA_W], bitwise inverted when addr MSB = 1.
REQ-033 SWEEP: k_cur held for cfg_dwell+1 cycles; then if k_cur + k_step > k_stop (compared at ACC_W+1 bits) k_cur <= k_start with sweep_done pulse, else k_cur <= k_cur + k_step.
REQ-034 k_start > k_stop: every step boundary wraps, pulsing sweep_done.
REQ-035 k_step = 0: k_cur constant, no sweep_done pulses.

Reset
REQ-036 rst asserted anytime, including mid-run: state IDLE, acc, k_cur, dwell counter, pipeline, config registers all zero.
REQ-037 Reset outputs: cfg_ready 1 (after release), busy 0, wave_out 0, wave_valid 0, sweep_done 0.

Structure
REQ-038 Package dds_pkg holds mode and FSM-state enumerations and default parameter constants.
REQ-039 Single sub-module dds_sine_lut (ADDR_W, DATA_W), one-cycle synchronous read, forms pipeline stage 2.

Verification
REQ-040 Fixed, mode 1, K=2^22, phase 0, start -> wave_valid rises 2 cycles after run entry, wave_out 0,1,2,3...; cfg_ready 0 throughout.
REQ-041 Same with phase 512 -> first sample 256, wraps 1023 -> 0.
REQ-042 Sweep, k_start 100, step 50, stop 200, dwell 1 -> k_cur 100,100,150,150,200,200,100; one sweep_done pulse at the wrap.
REQ-043 Mode 2 and 3, K=2^21 -> square 1023 for 1024 samples then 0; triangle ramps 0->1023 then 1023->0.
REQ-044 stop mid-run -> busy low next cycle, wave_valid low 2 cycles later; start ignored while busy; cfg_valid ignored while busy.
REQ-045 rst pulse mid-sweep -> all outputs zero immediately; restart reproduces REQ-042 sequence.
